// File: rtl/pixel_fifo.sv
// Parametrised single-clock pixel FIFO with occupancy count, programmable almost flags and synchronous flush.
// Define PIXEL_FIFO_ERR_EN to add sticky overflow/underflow flags and the clearErr input.
module pixel_fifo #(
   parameter int unsigned DATA_W   = 3,
   parameter int unsigned DEPTH    = 64,
   parameter int unsigned AF_LEVEL = DEPTH - 4,
   parameter int unsigned AE_LEVEL = 4
) (
   input  logic                       clock,
   input  logic                       resetN,
   input  logic                       flush,
   input  logic                       WE,
   input  logic [DATA_W-1:0]          dataIn,
   input  logic                       RE,
   output logic [DATA_W-1:0]          dataOut,
   output logic                       valid,
   output logic                       F,
   output logic                       E,
   output logic                       almostFull,
   output logic                       almostEmpty,
`ifdef PIXEL_FIFO_ERR_EN
   input  logic                       clearErr,
   output logic                       overflow,
   output logic                       underflow,
`endif
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic              racc;
   logic              wacc;
   logic              op_en;

   // A write at full is only taken when a read frees the slot in the same cycle.
   always_comb begin
      racc  = RE & ~E;
      wacc  = WE & (~F | racc);
      op_en = resetN & ~flush;
   end

   always_comb begin
      E           = (count == '0);
      F           = (count == FULL_C);
      almostFull  = (count >= AF_C);
      almostEmpty = (count <= AE_C);
   end

   // Storage has no reset so it maps onto plain RAM.
   always_ff @(posedge clock) begin
      if (op_en && wacc)
         mem[wptr] <= dataIn;
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         dataOut <= '0;
         valid   <= 1'b0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         valid <= 1'b0;
      end else begin
         valid <= racc;
         if (racc) begin
            dataOut <= mem[rptr];
            rptr    <= rptr + 1'b1;
         end
         if (wacc)
            wptr <= wptr + 1'b1;
         case ({wacc, racc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef PIXEL_FIFO_ERR_EN
   logic ovf_set;
   logic unf_set;

   always_comb begin
      ovf_set = op_en & WE & F & ~racc;
      unf_set = op_en & RE & E;
   end

   // Set takes priority over clearErr so no error event is ever lost.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ovf_set)
            overflow <= 1'b1;
         else if (clearErr)
            overflow <= 1'b0;
         if (unf_set)
            underflow <= 1'b1;
         else if (clearErr)
            underflow <= 1'b0;
      end
   end
`endif

endmodule
